// File: rtl/argmax_datapath_if.sv
// Read port of the result-matrix memory as seen by the argmax datapath.
// The datapath is the master: it issues the read strobe and row address,
// the memory answers one cycle later with a full row.
interface argmax_datapath_if #(
   parameter int ARGMAX_WIDTH = 3,
   parameter int ROW_WIDTH    = 48
);
   logic                    mem_read_en;
   logic [ARGMAX_WIDTH-1:0] mem_read_addr;
   logic [ROW_WIDTH-1:0]    mem_read_data;

   modport master (
      output mem_read_en,
      output mem_read_addr,
      input  mem_read_data
   );

   modport slave (
      input  mem_read_en,
      input  mem_read_addr,
      output mem_read_data
   );
endinterface

// File: rtl/argmax_datapath.sv
// Argmax datapath: walks the rows of a result matrix under control of an
// external controller, records the winning (largest signed) column of each
// row and flags when the full answer vector is available.
module argmax_datapath #(
   parameter int ARGMAX_ROWS  = 6,
   parameter int ARGMAX_COLS  = 3,
   parameter int DATA_WIDTH   = 16,
   parameter int ARGMAX_WIDTH = $clog2(ARGMAX_ROWS),
   parameter int COL_WIDTH    = (ARGMAX_COLS > 1) ? $clog2(ARGMAX_COLS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             is_idle,
   input  logic                             is_read_row,
   input  logic                             is_increment_row_addr,
   input  logic                             is_done,
   argmax_datapath_if.master                mem,
   output logic [ARGMAX_WIDTH-1:0]          ADJ_FM_WM_ROW_Counter,
   output logic [ARGMAX_ROWS*COL_WIDTH-1:0] max_addi_answer,
   output logic                             answer_valid
);

   localparam logic [ARGMAX_WIDTH-1:0] LAST_ROW = ARGMAX_WIDTH'(ARGMAX_ROWS - 1);

   logic [ARGMAX_WIDTH-1:0]          counter_q, counter_d;
   logic [ARGMAX_ROWS*COL_WIDTH-1:0] answer_q, answer_d;
   logic                             valid_q, valid_d;

   logic signed [DATA_WIDTH-1:0] col_val [ARGMAX_COLS];
   logic signed [DATA_WIDTH-1:0] best_val;
   logic [COL_WIDTH-1:0]         best_idx;

   // Unpack the row returned by memory into one signed element per column.
   genvar gi;
   generate
      for (gi = 0; gi < ARGMAX_COLS; gi++) begin : g_unpack
         assign col_val[gi] = mem.mem_read_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Address and strobe track the controller and row counter directly.
   assign mem.mem_read_addr    = counter_q;
   assign mem.mem_read_en      = is_read_row;
   assign ADJ_FM_WM_ROW_Counter = counter_q;
   assign max_addi_answer       = answer_q;
   assign answer_valid          = valid_q;

   // Signed argmax across columns; strict greater-than keeps the lowest index on ties.
   always_comb begin
      best_val = col_val[0];
      best_idx = '0;
      for (int c = 1; c < ARGMAX_COLS; c++) begin
         if (col_val[c] > best_val) begin
            best_val = col_val[c];
            best_idx = COL_WIDTH'(c);
         end
      end
   end

   // Next-state selection with priority idle > increment > done; read/no-flag cycles hold.
   always_comb begin
      counter_d = counter_q;
      answer_d  = answer_q;
      valid_d   = valid_q;
      if (is_idle) begin
         counter_d = '0;
         valid_d   = 1'b0;
      end else if (is_increment_row_addr) begin
         for (int r = 0; r < ARGMAX_ROWS; r++) begin
            if (counter_q == ARGMAX_WIDTH'(r)) begin
               answer_d[r*COL_WIDTH +: COL_WIDTH] = best_idx;
            end
         end
         if (counter_q < LAST_ROW) begin
            counter_d = counter_q + 1'b1;
         end
      end else if (is_done) begin
         valid_d = 1'b1;
      end
   end

   // State registers; reset clears everything so a restarted run carries nothing over.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter_q <= '0;
         answer_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         counter_q <= counter_d;
         answer_q  <= answer_d;
         valid_q   <= valid_d;
      end
   end

endmodule

// File: tb/tb_argmax_datapath.sv
// Directed bench for argmax_datapath: drives controller flags, models a
// one-cycle-latency row memory and checks answers against hand-computed slots.
module tb_argmax_datapath;

   localparam int ROWS = 6;
   localparam int COLS = 3;
   localparam int DW   = 16;
   localparam int AW   = 3;
   localparam int CW   = 2;

   logic clk = 1'b0;
   logic reset;
   logic is_idle, is_read_row, is_increment_row_addr, is_done;
   logic [AW-1:0]      row_counter;
   logic [ROWS*CW-1:0] answer;
   logic               answer_valid;

   int checks = 0;
   int errors = 0;

   logic [COLS*DW-1:0] mem_arr [ROWS];
   logic [COLS*DW-1:0] rd_q;

   always #5 clk = ~clk;

   argmax_datapath_if #(.ARGMAX_WIDTH(AW), .ROW_WIDTH(COLS*DW)) mem_if ();

   argmax_datapath #(
      .ARGMAX_ROWS(ROWS),
      .ARGMAX_COLS(COLS),
      .DATA_WIDTH (DW)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .is_idle              (is_idle),
      .is_read_row          (is_read_row),
      .is_increment_row_addr(is_increment_row_addr),
      .is_done              (is_done),
      .mem                  (mem_if),
      .ADJ_FM_WM_ROW_Counter(row_counter),
      .max_addi_answer      (answer),
      .answer_valid         (answer_valid)
   );

   // One-cycle-latency memory model
   always @(posedge clk) begin
      if (mem_if.mem_read_en) rd_q <= mem_arr[mem_if.mem_read_addr];
   end
   assign mem_if.mem_read_data = rd_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   function automatic logic [ROWS*CW-1:0] pack(input int s0, input int s1, input int s2,
                                               input int s3, input int s4, input int s5);
      logic [ROWS*CW-1:0] v;
      v = '0;
      v[0*CW +: CW] = CW'(s0);
      v[1*CW +: CW] = CW'(s1);
      v[2*CW +: CW] = CW'(s2);
      v[3*CW +: CW] = CW'(s3);
      v[4*CW +: CW] = CW'(s4);
      v[5*CW +: CW] = CW'(s5);
      return v;
   endfunction

   function automatic logic [COLS*DW-1:0] mkrow(input int c0, input int c1, input int c2);
      logic [DW-1:0] a, b, c;
      a = DW'(c0);
      b = DW'(c1);
      c = DW'(c2);
      return {c, b, a};
   endfunction

   task automatic load_nominal();
      mem_arr[0] = mkrow(5, 2, 1);
      mem_arr[1] = mkrow(0, 9, 3);
      mem_arr[2] = mkrow(1, 1, 7);
      mem_arr[3] = mkrow(-4, -2, -8);
      mem_arr[4] = mkrow(6, 6, 0);
      mem_arr[5] = mkrow(2, 3, 3);
   endtask

   task automatic clear_flags();
      is_idle = 0; is_read_row = 0; is_increment_row_addr = 0; is_done = 0;
   endtask

   // Read row then increment; checks strobe/address in the read cycle and the counter after.
   task automatic do_row(input int r, input int exp_cnt);
      @(negedge clk);
      clear_flags();
      is_read_row = 1;
      #1;
      chk($sformatf("rd_en_r%0d", r), 32'(mem_if.mem_read_en), 32'd1);
      chk($sformatf("rd_addr_r%0d", r), 32'(mem_if.mem_read_addr), 32'(r));
      @(negedge clk);
      is_read_row = 0;
      is_increment_row_addr = 1;
      @(negedge clk);
      is_increment_row_addr = 0;
      chk($sformatf("cnt_after_r%0d", r), 32'(row_counter), 32'(exp_cnt));
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      clear_flags();
      is_idle = 1;
      @(negedge clk);
      is_idle = 0;
   endtask

   task automatic full_run();
      for (int r = 0; r < ROWS; r++) do_row(r, (r < ROWS-1) ? r+1 : ROWS-1);
   endtask

   logic [ROWS*CW-1:0] exp_nom, exp_sat, exp_bnd;

   initial begin
      exp_nom = pack(0, 1, 2, 1, 0, 1);
      exp_sat = pack(0, 1, 2, 1, 0, 2);
      exp_bnd = pack(1, 0, 2, 2, 2, 0);
      rd_q = '0;
      clear_flags();
      reset = 1;
      load_nominal();

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_counter", 32'(row_counter), 32'd0);
      chk("rst_answer", 32'(answer), 32'd0);
      chk("rst_valid", 32'(answer_valid), 32'd0);
      chk("rst_rd_en", 32'(mem_if.mem_read_en), 32'd0);
      chk("rst_rd_addr", 32'(mem_if.mem_read_addr), 32'd0);
      reset = 0;

      // Nominal run
      idle_cycle();
      full_run();
      chk("nom_answer", 32'(answer), 32'(exp_nom));
      chk("nom_valid_pre", 32'(answer_valid), 32'd0);

      // Saturation: a seventh increment rewrites slot 5 only
      mem_arr[5] = mkrow(-5, -3, 100);
      do_row(5, 5);
      chk("sat_answer", 32'(answer), 32'(exp_sat));

      // Done for three cycles, then idle
      @(negedge clk);
      is_done = 1;
      #1;
      chk("done_valid_same_cycle", 32'(answer_valid), 32'd0);
      @(negedge clk);
      chk("done_valid_rise", 32'(answer_valid), 32'd1);
      chk("done_cnt_hold", 32'(row_counter), 32'd5);
      @(negedge clk);
      @(negedge clk);
      chk("done_ans_hold", 32'(answer), 32'(exp_sat));
      is_done = 0;
      is_idle = 1;
      @(negedge clk);
      is_idle = 0;
      chk("idle_valid_fall", 32'(answer_valid), 32'd0);
      chk("idle_cnt", 32'(row_counter), 32'd0);
      chk("idle_ans_kept", 32'(answer), 32'(exp_sat));

      // Signed boundary run
      mem_arr[0] = mkrow(-32768, 32767, -1);
      mem_arr[1] = mkrow(-1, -1, -1);
      mem_arr[2] = mkrow(3, -7, 4);
      mem_arr[3] = mkrow(-100, -200, -50);
      mem_arr[4] = mkrow(0, 0, 1);
      mem_arr[5] = mkrow(7, 7, 7);
      full_run();
      chk("bnd_answer", 32'(answer), 32'(exp_bnd));

      // Reset mid-run during the row-3 increment
      idle_cycle();
      load_nominal();
      for (int r = 0; r < 3; r++) do_row(r, r+1);
      @(negedge clk);
      is_read_row = 1;
      @(negedge clk);
      is_read_row = 0;
      is_increment_row_addr = 1;
      reset = 1;
      @(negedge clk);
      reset = 0;
      is_increment_row_addr = 0;
      chk("mid_rst_cnt", 32'(row_counter), 32'd0);
      chk("mid_rst_ans", 32'(answer), 32'd0);
      chk("mid_rst_valid", 32'(answer_valid), 32'd0);
      idle_cycle();
      full_run();
      chk("rerun_answer", 32'(answer), 32'(exp_nom));
      @(negedge clk);
      is_done = 1;
      @(negedge clk);
      is_done = 0;
      chk("rerun_valid", 32'(answer_valid), 32'd1);

      // Flag conflict: idle wins over increment, no slot write
      idle_cycle();
      mem_arr[2] = mkrow(9, 0, 0);
      do_row(0, 1);
      do_row(1, 2);
      @(negedge clk);
      is_read_row = 1;
      @(negedge clk);
      is_read_row = 0;
      is_idle = 1;
      is_increment_row_addr = 1;
      @(negedge clk);
      clear_flags();
      chk("conflict_cnt", 32'(row_counter), 32'd0);
      chk("conflict_ans", 32'(answer), 32'(exp_nom));
      chk("conflict_valid", 32'(answer_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
